pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Drives the PLL `rst` input and consumes its `locked` output.
- Runs on the 50 MHz reference clock, so it keeps working when the PLL output clocks are absent.
- Pulses PLL reset, waits for lock, and qualifies lock as stable for a programmed time before releasing the system reset to the core clock domains.
- Re-issues PLL reset on lock loss or lock timeout, and flags a fault after too many failed attempts.

Parameters:
- PLL_RST_CYCLES, 16: cycles `pll_rst` is held high per reset pulse (must be ≥1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before release (must be ≥1).
- LOCK_TIMEOUT_CYCLES, 500000: cycles allowed in WAIT_LOCK before a retry (10 ms at 50 MHz).
- MAX_RETRIES, 3: retries after the first attempt before entering FAULT.

Ports:
- refclk  in  1  50 MHz reference clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  raw PLL `locked`; asynchronous to refclk.
- pll_rst  out  1  reset to PLL; high = PLL in reset.
- sys_rst  out  1  active-high reset to downstream logic; high until RUN.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_count  out  2  retries consumed; saturates at MAX_RETRIES.

Behaviour:
- **Lock synchronizer:** `pll_locked` passes through a 2-flop synchronizer to give `lock_s`. Synchronizer flops reset to 0. All decisions use `lock_s` only, so the minimum response latency is 2 cycles.
- **Counter:** one shared down-counter, wide enough for the largest parameter, reloaded on every state entry.
- **Reset:** while `rst` is high, state = PLL_RESET with the counter loaded to PLL_RST_CYCLES.
  - Outputs during reset: `pll_rst`=1, `sys_rst`=1, `ready`=0, `fault`=0, `retry_count`=0.
  - `rst` asserted mid-operation, in any state, forces this within 1 cycle.
- **PLL_RESET:** `pll_rst`=1, `sys_rst`=1. After PLL_RST_CYCLES cycles, go to WAIT_LOCK. `pll_rst` is high for exactly PLL_RST_CYCLES cycles per pulse.
- **WAIT_LOCK:** `pll_rst`=0, `sys_rst`=1.
  - `lock_s`=1 → STABILIZE.
  - Timeout expiry with `lock_s`=0 → retry path.
  - If `lock_s` rises on the same cycle as expiry, lock wins.
- **STABILIZE:** `sys_rst`=1.
  - `lock_s`=0 at any point → back to WAIT_LOCK with the timeout reloaded. This is a glitch, not a retry; `retry_count` is unchanged.
  - LOCK_STABLE_CYCLES consecutive high cycles → RUN.
- **RUN:** `sys_rst`=0, `ready`=1. `sys_rst` falls on the first RUN cycle.
  - `lock_s`=0 → retry path. `sys_rst` returns to 1 on the next cycle, i.e. 3 cycles after the raw `pll_locked` falls.
- **Retry path:**
  - If `retry_count` < MAX_RETRIES: increment it and go to PLL_RESET.
  - Otherwise go to FAULT.
- **FAULT:** `pll_rst`=1, `sys_rst`=1, `fault`=1. Held until `rst`; `lock_s` is ignored.
- **retry_count lifetime:** cleared only by `rst`. Lock loss in RUN consumes a retry.
- **Output timing:** all outputs are registered and glitch-free.

Optional Feature:
- Macro: `PLL_LOCK_LOSS_STATS_EN`.
- **Defined:**
  - Adds output `lock_loss_count`, 8 bits: a saturating count of RUN→lock-loss events. Reset 0; holds at 255.
  - Adds input `stats_clear`, 1 bit: synchronous clear. If clear and increment occur on the same cycle, clear wins.
- **Undefined:** neither port exists, and no counter logic is instantiated.

Decomposition:
- **Shared package `pll_pkg`:**
  - state enum `pll_sup_state_t` (PLL_RESET, WAIT_LOCK, STABILIZE, RUN, FAULT);
  - a width helper function giving the counter width from the maximum parameter value.
- **Sub-module `sync_2ff`:** the single-bit 2-flop synchronizer, reusable elsewhere.
- The FSM and counter remain in this module.

Test Plan:
- **Clean lock:** release `rst`; raise `pll_locked` 100 cycles after `pll_rst` falls; hold it.
  - `pll_rst` high for 16 cycles.
  - `sys_rst` falls exactly 2+1024 cycles after `pll_locked` rises.
  - `ready`=1, `retry_count`=0.
- **Glitch during STABILIZE:** drop `pll_locked` for 3 cycles at stable-count 500.
  - FSM returns to WAIT_LOCK, stable count restarts.
  - No new `pll_rst` pulse, `retry_count`=0, `sys_rst` stays 1 throughout.
- **Timeout:** keep `pll_locked`=0.
  - Set LOCK_TIMEOUT_CYCLES=1000 and MAX_RETRIES=3 in the bench.
  - Four `pll_rst` pulses, then `fault`=1 and `retry_count`=3.
  - FAULT persists until `rst`.
- **Loss in RUN:** reach RUN, then drop `pll_locked`.
  - `sys_rst`=1 and `ready`=0 within 3 cycles.
  - A new 16-cycle `pll_rst` pulse, `retry_count`=1.
  - Relock restores RUN.
- **Mid-operation reset:** assert `rst` for 1 cycle during STABILIZE.
  - Next cycle: `pll_rst`=1, `retry_count`=0, `sys_rst`=1.
  - The full sequence restarts.
- **Stats (macro defined):** cause 300 lock-loss events in RUN with large MAX_RETRIES.
  - `lock_loss_count` saturates at 255.
  - `stats_clear` coincident with a loss event gives 0.

Source files
------------

// File: rtl/pll_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pll_pkg;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_sup_state_t;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for a level signal crossing into clk.
// Latency: 2 clk cycles from input capture to q.
// Backpressure: none; the input is sampled every cycle.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; both stages clear to 0 on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses PLL reset, qualifies lock, releases sys_rst; optional lock-loss stats (PLL_LOCK_LOSS_STATS_EN).
// Latency: raw pll_locked change reaches the FSM after 2 cycles; all outputs registered (+1 cycle).
// Backpressure: none; free-running on refclk, lock loss re-enters reset through the retry path.
module pll_lock_supervisor
    import pll_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
`ifdef PLL_LOCK_LOSS_STATS_EN
    input  logic       stats_clear,
    output logic [7:0] lock_loss_count,
`endif
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_count
);

    localparam int unsigned MAX_A    = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_LOAD = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CW       = cnt_width(MAX_LOAD);
    // Internal retry counter may be wider than the 2-bit port, which saturates at 3.
    localparam int unsigned RW       = (cnt_width(MAX_RETRIES) < 2) ? 2 : cnt_width(MAX_RETRIES);

    pll_sup_state_t  state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            lock_s;
    logic            retry_req;
    logic            loss_evt;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // Next-state, shared down-counter reload and retry accounting.
    // The cycle that leaves WAIT_LOCK already saw lock_s high, so it counts as the first stable cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q - 1'b1;
        retry_d   = retry_q;
        retry_req = 1'b0;
        loss_evt  = 1'b0;
        case (state_q)
            PLL_RESET: begin
                if (cnt_q == CW'(1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = CW'(LOCK_TIMEOUT_CYCLES);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    if (LOCK_STABLE_CYCLES <= 1) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        state_d = STABILIZE;
                        cnt_d   = CW'(LOCK_STABLE_CYCLES - 1);
                    end
                end else if (cnt_q == CW'(1)) begin
                    retry_req = 1'b1;
                end
            end
            STABILIZE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = CW'(LOCK_TIMEOUT_CYCLES);
                end else if (cnt_q == CW'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    retry_req = 1'b1;
                    loss_evt  = 1'b1;
                end
            end
            default: begin
                state_d = FAULT;
                cnt_d   = '0;
            end
        endcase
        if (retry_req) begin
            if (retry_q < RW'(MAX_RETRIES)) begin
                retry_d = retry_q + 1'b1;
                state_d = PLL_RESET;
                cnt_d   = CW'(PLL_RST_CYCLES);
            end else begin
                state_d = FAULT;
                cnt_d   = '0;
            end
        end
    end

    // State, counter and outputs registered together; outputs decode the next state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= PLL_RESET;
            cnt_q       <= CW'(PLL_RST_CYCLES);
            retry_q     <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
            retry_count <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst     <= (state_d == PLL_RESET) || (state_d == FAULT);
            sys_rst     <= (state_d != RUN);
            ready       <= (state_d == RUN);
            fault       <= (state_d == FAULT);
            retry_count <= (retry_d > RW'(3)) ? 2'd3 : retry_d[1:0];
        end
    end

`ifdef PLL_LOCK_LOSS_STATS_EN
    logic [7:0] loss_cnt_q;

    // Saturating count of lock losses while running; clear beats a coincident increment.
    always_ff @(posedge refclk) begin
        if (rst || stats_clear) begin
            loss_cnt_q <= 8'd0;
        end else if (loss_evt && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign lock_loss_count = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor; covers stats ports when PLL_LOCK_LOSS_STATS_EN is defined.
// Latency: n/a.
// Backpressure: n/a.
module tb_pll_lock_supervisor;

    localparam int unsigned RSTC = 16;
    localparam int unsigned STAB = 1024;
    localparam int unsigned TMO  = 1000;
    localparam int unsigned MAXR = 3;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_rst, ready, fault;
    logic [1:0] retry_count;

    int checks = 0;
    int errors = 0;

    always #10 refclk = ~refclk;

`ifdef PLL_LOCK_LOSS_STATS_EN
    logic       st_clear = 1'b0;
    logic       st_locked = 1'b0;
    logic       st_pll_rst, st_sys_rst, st_ready, st_fault;
    logic [1:0] st_retry;
    logic [7:0] st_count, main_count;
`endif

    pll_lock_supervisor #(
        .PLL_RST_CYCLES      (RSTC),
        .LOCK_STABLE_CYCLES  (STAB),
        .LOCK_TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES         (MAXR)
    ) dut (
        .refclk          (refclk),
        .rst             (rst),
        .pll_locked      (pll_locked),
`ifdef PLL_LOCK_LOSS_STATS_EN
        .stats_clear     (st_clear),
        .lock_loss_count (main_count),
`endif
        .pll_rst         (pll_rst),
        .sys_rst         (sys_rst),
        .ready           (ready),
        .fault           (fault),
        .retry_count     (retry_count)
    );

`ifdef PLL_LOCK_LOSS_STATS_EN
    pll_lock_supervisor #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (2),
        .LOCK_TIMEOUT_CYCLES (100),
        .MAX_RETRIES         (400)
    ) u_st (
        .refclk          (refclk),
        .rst             (rst),
        .pll_locked      (st_locked),
        .stats_clear     (st_clear),
        .lock_loss_count (st_count),
        .pll_rst         (st_pll_rst),
        .sys_rst         (st_sys_rst),
        .ready           (st_ready),
        .fault           (st_fault),
        .retry_count     (st_retry)
    );
`endif

    typedef struct {
        logic       rst;
        logic       locked;
        int         cycles;
        logic       pll_rst;
        logic       sys_rst;
        logic       ready;
        logic       fault;
        logic [1:0] retry;
    } vec_t;

    typedef struct {
        int         id;
        logic       pll_rst;
        logic       sys_rst;
        logic       ready;
        logic       fault;
        logic [1:0] retry;
    } exp_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];
    exp_t sb[$];

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic r, input logic l, input int c,
                           input logic pr, input logic sr, input logic rd, input logic ft,
                           input logic [1:0] rc);
        vecs[i].rst     = r;
        vecs[i].locked  = l;
        vecs[i].cycles  = c;
        vecs[i].pll_rst = pr;
        vecs[i].sys_rst = sr;
        vecs[i].ready   = rd;
        vecs[i].fault   = ft;
        vecs[i].retry   = rc;
    endtask

    task automatic apply_vec(input int i);
        exp_t e;
        rst        = vecs[i].rst;
        pll_locked = vecs[i].locked;
        e.id       = i;
        e.pll_rst  = vecs[i].pll_rst;
        e.sys_rst  = vecs[i].sys_rst;
        e.ready    = vecs[i].ready;
        e.fault    = vecs[i].fault;
        e.retry    = vecs[i].retry;
        sb.push_back(e);
        repeat (vecs[i].cycles) tick();
        e = sb.pop_front();
        chk($sformatf("vec%0d pll_rst", e.id), 32'(pll_rst), 32'(e.pll_rst));
        chk($sformatf("vec%0d sys_rst", e.id), 32'(sys_rst), 32'(e.sys_rst));
        chk($sformatf("vec%0d ready", e.id), 32'(ready), 32'(e.ready));
        chk($sformatf("vec%0d fault", e.id), 32'(fault), 32'(e.fault));
        chk($sformatf("vec%0d retry_count", e.id), 32'(retry_count), 32'(e.retry));
    endtask

    initial begin
        int n;
        int m;
        int bad;
        int pulses;
        int fault_at;
        logic prev;

        //          rst locked cycles  pll_rst sys_rst ready fault retry
        set_vec(0,  1, 0, 3,           1, 1, 0, 0, 0);  // held in reset
        set_vec(1,  0, 0, RSTC - 1,    1, 1, 0, 0, 0);  // last cycle of first pulse
        set_vec(2,  0, 0, 1,           0, 1, 0, 0, 0);  // pll_rst falls after exactly RSTC
        set_vec(3,  0, 0, 99,          0, 1, 0, 0, 0);  // waiting for lock
        set_vec(4,  0, 1, 2 + STAB - 1, 0, 1, 0, 0, 0); // one cycle before release
        set_vec(5,  0, 1, 1,           0, 0, 1, 0, 0);  // release at 2+STAB
        set_vec(6,  0, 1, 10,          0, 0, 1, 0, 0);  // running
        set_vec(7,  0, 0, 2,           0, 0, 1, 0, 0);  // loss still in synchronizer
        set_vec(8,  0, 0, 1,           1, 1, 0, 0, 1);  // loss acted on: 3 cycles
        set_vec(9,  0, 0, RSTC - 1,    1, 1, 0, 0, 1);  // retry pulse continues
        set_vec(10, 0, 0, 1,           0, 1, 0, 0, 1);  // retry pulse is RSTC long
        set_vec(11, 0, 1, 2 + STAB,    0, 0, 1, 0, 1);  // relock restores RUN
        set_vec(12, 0, 0, 3,           1, 1, 0, 0, 2);  // second loss
        set_vec(13, 0, 1, RSTC,        0, 1, 0, 0, 2);  // back to waiting
        set_vec(14, 0, 1, 100,         0, 1, 0, 0, 2);  // stabilizing
        set_vec(15, 1, 1, 1,           1, 1, 0, 0, 0);  // mid-operation reset

        tick();
        for (int i = 0; i < NVEC; i++) apply_vec(i);

        // Sequence restarts after the mid-operation reset with lock held high.
        rst = 1'b0;
        n = 0;
        while (pll_rst && n < 200) begin
            tick();
            n++;
        end
        chk("restart pll_rst pulse length", 32'(n), 32'(RSTC));
        m = 0;
        while (sys_rst && m < 3000) begin
            tick();
            m++;
        end
        chk("restart cycles to release", 32'(m), 32'(STAB));

        // Glitch during STABILIZE: no retry, stable count restarts.
        rst = 1'b1;
        pll_locked = 1'b0;
        tick();
        rst = 1'b0;
        n = 0;
        while (pll_rst && n < 200) begin
            tick();
            n++;
        end
        repeat (50) tick();
        pll_locked = 1'b1;
        repeat (502) tick();
        bad = 0;
        pll_locked = 1'b0;
        repeat (3) begin
            tick();
            if (pll_rst || retry_count != 2'd0 || !sys_rst) bad++;
        end
        pll_locked = 1'b1;
        n = 0;
        while (sys_rst && n < 3000) begin
            tick();
            n++;
            if (pll_rst || retry_count != 2'd0) bad++;
        end
        chk("glitch disturbances", 32'(bad), 32'd0);
        chk("glitch cycles to release", 32'(n), 32'(2 + STAB));
        chk("glitch ready", 32'(ready), 32'd1);

        // Timeout: lock never arrives.
        pll_locked = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulses = 1;
        prev = 1'b1;
        fault_at = -1;
        for (int c = 1; c <= 6000; c++) begin
            tick();
            if (fault) begin
                fault_at = c;
                break;
            end
            if (pll_rst && !prev) pulses++;
            prev = pll_rst;
        end
        chk("timeout pll_rst pulses", 32'(pulses), 32'(MAXR + 1));
        chk("timeout cycle of fault", 32'(fault_at), 32'((MAXR + 1) * (RSTC + TMO)));
        chk("timeout retry_count", 32'(retry_count), 32'(MAXR));
        pll_locked = 1'b1;
        repeat (200) tick();
        chk("fault held", 32'(fault), 32'd1);
        chk("fault pll_rst", 32'(pll_rst), 32'd1);
        chk("fault sys_rst", 32'(sys_rst), 32'd1);
        chk("fault ready", 32'(ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("fault cleared by rst", 32'(fault), 32'd0);
        chk("retry cleared by rst", 32'(retry_count), 32'd0);

`ifdef PLL_LOCK_LOSS_STATS_EN
        chk("main lock_loss_count after rst", 32'(main_count), 32'd0);
        chk("stats reset value", 32'(st_count), 32'd0);
        bad = 0;
        for (int ev = 0; ev < 300; ev++) begin
            st_locked = 1'b1;
            n = 0;
            while (!st_ready && n < 200) begin
                tick();
                n++;
            end
            if (!st_ready) bad++;
            st_locked = 1'b0;
            n = 0;
            while (st_ready && n < 20) begin
                tick();
                n++;
            end
            if (st_ready) bad++;
        end
        chk("stats loop stalls", 32'(bad), 32'd0);
        chk("stats saturates", 32'(st_count), 32'd255);
        chk("stats retry_count port saturates", 32'(st_retry), 32'd3);
        chk("stats not faulted", 32'(st_fault), 32'd0);
        st_locked = 1'b1;
        n = 0;
        while (!st_ready && n < 200) begin
            tick();
            n++;
        end
        chk("stats sys_rst in RUN", 32'(st_sys_rst), 32'd0);
        st_locked = 1'b0;
        tick();
        tick();
        st_clear = 1'b1;
        tick();
        st_clear = 1'b0;
        chk("stats loss taken", 32'(st_ready), 32'd0);
        chk("stats pll_rst on loss", 32'(st_pll_rst), 32'd1);
        chk("stats clear beats increment", 32'(st_count), 32'd0);
        st_locked = 1'b1;
        n = 0;
        while (!st_ready && n < 200) begin
            tick();
            n++;
        end
        st_locked = 1'b0;
        repeat (3) tick();
        chk("stats counts after clear", 32'(st_count), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
